// File: rtl/mem_model_2p_if.sv
// Bus bundle for the two-port memory model: port A read-only fetch,
// port B SRAM-style read/write with active-low controls.
interface mem_model_2p_if #(
  parameter int DATA_W = 32
);
  logic              a_req;
  logic [31:0]       a_addr;
  logic [DATA_W-1:0] a_rdata;
  logic              a_valid;
  logic              b_cen;
  logic              b_wen;
  logic [DATA_W/8-1:0] b_ben;
  logic [31:0]       b_addr;
  logic [DATA_W-1:0] b_din;
  logic [DATA_W-1:0] b_dout;
  logic              b_valid;
  logic              oor;
  logic              oor_clr;

  modport master (
    output a_req, a_addr, b_cen, b_wen, b_ben, b_addr, b_din, oor_clr,
    input  a_rdata, a_valid, b_dout, b_valid, oor
  );

  modport slave (
    input  a_req, a_addr, b_cen, b_wen, b_ben, b_addr, b_din, oor_clr,
    output a_rdata, a_valid, b_dout, b_valid, oor
  );
endinterface

// File: rtl/mem_model_2p.sv
// Two-port behavioural memory with configurable read latency, byte-masked
// writes on port B, read-first collision ordering and a sticky range flag.
module mem_model_2p #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  mem_model_2p_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0]       a_shift;
  logic [31:0]       b_shift;
  logic [AW-1:0]     a_idx;
  logic [AW-1:0]     b_idx;
  logic              a_oor;
  logic              b_oor;
  logic              b_access;
  logic              b_write;

  logic [RD_LAT-1:0] a_vld;
  logic [RD_LAT-1:0] b_vld;
  logic [DATA_W-1:0] a_dat [RD_LAT];
  logic [DATA_W-1:0] b_dat [RD_LAT];
  logic              oor_q;

  // Any address bit above the word index marks the access out of range.
  assign a_shift  = bus.a_addr >> OFF;
  assign b_shift  = bus.b_addr >> OFF;
  assign a_idx    = a_shift[AW-1:0];
  assign b_idx    = b_shift[AW-1:0];
  assign a_oor    = |(a_shift >> AW);
  assign b_oor    = |(b_shift >> AW);
  assign b_access = !bus.b_cen;
  assign b_write  = b_access && !bus.b_wen && !b_oor;

  // Contents are deliberately not reset so they survive a reset pulse.
  always_ff @(posedge clk) begin
    if (rst_n && b_write) begin
      for (int i = 0; i < NB; i++) begin
        if (!bus.b_ben[i]) mem[b_idx][8*i +: 8] <= bus.b_din[8*i +: 8];
      end
    end
  end

  // Stage 0 samples the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_vld <= '0;
      b_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        a_dat[i] <= '0;
        b_dat[i] <= '0;
      end
      oor_q <= 1'b0;
    end else begin
      a_vld[0] <= bus.a_req;
      b_vld[0] <= b_access;
      a_dat[0] <= (bus.a_req && !a_oor) ? mem[a_idx] : '0;
      b_dat[0] <= (b_access && !b_oor) ? mem[b_idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        a_vld[i] <= a_vld[i-1];
        b_vld[i] <= b_vld[i-1];
        a_dat[i] <= a_dat[i-1];
        b_dat[i] <= b_dat[i-1];
      end
      if ((bus.a_req && a_oor) || (b_access && b_oor)) oor_q <= 1'b1;
      else if (bus.oor_clr) oor_q <= 1'b0;
    end
  end

  assign bus.a_valid = a_vld[RD_LAT-1];
  assign bus.b_valid = b_vld[RD_LAT-1];
  assign bus.a_rdata = a_dat[RD_LAT-1];
  assign bus.b_dout  = b_dat[RD_LAT-1];
  assign bus.oor     = oor_q;
endmodule
